// File: rtl/up3_pkg.sv
// Shared types and defaults for the uP3 front-panel execution controller.
package up3_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } step_state_t;

    localparam int DEB_CYCLES_DEF = 500000;
    localparam int RUN_DIV_DEF    = 12500000;
    localparam int REPEAT_DLY_DEF = 25000000;
    localparam int STEP_CNT_W     = 16;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/up3_step_ctrl_if.sv
// Front-panel bundle: raw keys and halt request in, CPU enable and status out.
interface up3_step_ctrl_if;

    logic                         step_key_n;
    logic                         run_key_n;
    logic                         mode_key_n;
    logic                         halt_in;
    logic                         cpu_en;
    logic                         running;
    logic                         halted;
    logic                         disp_mode;
    logic [up3_pkg::STEP_CNT_W-1:0] step_cnt;

    modport master (
        output step_key_n, run_key_n, mode_key_n, halt_in,
        input  cpu_en, running, halted, disp_mode, step_cnt
    );

    modport slave (
        input  step_key_n, run_key_n, mode_key_n, halt_in,
        output cpu_en, running, halted, disp_mode, step_cnt
    );

endinterface

// File: rtl/up3_step_ctrl_key_debounce.sv
// Two-flop synchroniser, stability-counter debounce and one-cycle press pulse
// for one active-low push button.
module key_debounce
    import up3_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int              CW      = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1, sync2;
    logic          stable, stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: synchroniser and debounced state reset to "released" so no press is seen on reset exit.
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            stable      <= 1'b1;
            stable_q    <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= key_n;
            sync2       <= sync1;
            stable_q    <= stable;
            press_pulse <= stable_q & ~stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign pressed = ~stable;

endmodule

// File: rtl/up3_step_ctrl.sv
// uP3 execution controller: single-step / free-run CPU enable generation.
// Optional step auto-repeat is built when UP3_STEP_AUTOREPEAT_EN is defined.
module up3_step_ctrl
    import up3_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int RUN_DIV    = RUN_DIV_DEF,
    parameter int REPEAT_DLY = REPEAT_DLY_DEF
) (
    input  logic           clk,
    input  logic           reset,
    up3_step_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_RUN  = S_RUN;
    localparam logic [1:0] ST_HALT = S_HALT;

    localparam int                TICK_W   = cnt_w(RUN_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(RUN_DIV - 1);

    if (RUN_DIV < 2 || DEB_CYCLES < 1 || REPEAT_DLY < 1) begin : g_bad_param
        $error("up3_step_ctrl: RUN_DIV must be >= 2, DEB_CYCLES and REPEAT_DLY >= 1");
    end

    logic                  step_held, run_held, mode_held;
    logic                  step_press, run_press, mode_press;
    logic [1:0]            state;
    logic [TICK_W-1:0]     tick;
    logic                  cpu_en, disp_mode;
    logic [STEP_CNT_W-1:0] step_cnt;
    logic                  rpt_fire;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
        .clk(clk), .reset(reset), .key_n(bus.step_key_n),
        .pressed(step_held), .press_pulse(step_press)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
        .clk(clk), .reset(reset), .key_n(bus.run_key_n),
        .pressed(run_held), .press_pulse(run_press)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
        .clk(clk), .reset(reset), .key_n(bus.mode_key_n),
        .pressed(mode_held), .press_pulse(mode_press)
    );

`ifdef UP3_STEP_AUTOREPEAT_EN
    localparam int              RW      = cnt_w(REPEAT_DLY);
    localparam logic [RW-1:0]   RPT_MAX = RW'(REPEAT_DLY - 1);

    logic              rpt_arm, rpt_on;
    logic [RW-1:0]     rpt_cnt;
    logic [TICK_W-1:0] rpt_tick;
    logic              idle_ok;
    logic              unused_held;

    assign idle_ok     = (state == ST_IDLE) && !bus.halt_in && !run_press;
    assign rpt_fire    = rpt_arm && step_held && (rpt_on ? (rpt_tick == TICK_MAX) : (rpt_cnt == RPT_MAX));
    assign unused_held = run_held | mode_held;

    // Armed by a step press in idle; first repeat after REPEAT_DLY, then every RUN_DIV.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_arm  <= 1'b0;
            rpt_on   <= 1'b0;
            rpt_cnt  <= '0;
            rpt_tick <= '0;
        end else if (!idle_ok) begin
            rpt_arm <= 1'b0;
            rpt_on  <= 1'b0;
        end else if (step_press) begin
            rpt_arm <= 1'b1;
            rpt_on  <= 1'b0;
            rpt_cnt <= '0;
        end else if (rpt_arm) begin
            if (!step_held) begin
                rpt_arm <= 1'b0;
                rpt_on  <= 1'b0;
            end else if (!rpt_on) begin
                if (rpt_cnt == RPT_MAX) begin
                    rpt_on   <= 1'b1;
                    rpt_tick <= '0;
                end else begin
                    rpt_cnt <= rpt_cnt + RW'(1);
                end
            end else begin
                rpt_tick <= (rpt_tick == TICK_MAX) ? '0 : rpt_tick + TICK_W'(1);
            end
        end
    end
`else
    logic unused_held;

    assign rpt_fire    = 1'b0;
    assign unused_held = step_held | run_held | mode_held;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tick      <= '0;
            cpu_en    <= 1'b0;
            disp_mode <= 1'b0;
            step_cnt  <= '0;
        end else begin
            cpu_en <= 1'b0;
            if (cpu_en)     step_cnt  <= step_cnt + STEP_CNT_W'(1);
            if (mode_press) disp_mode <= ~disp_mode;
            // Priority in every active state: halt, then run key, then tick/step.
            case (state)
                ST_IDLE: begin
                    if (bus.halt_in) begin
                        state <= ST_HALT;
                    end else if (run_press) begin
                        state <= ST_RUN;
                        tick  <= '0;
                    end else if (step_press || rpt_fire) begin
                        cpu_en <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.halt_in) begin
                        state <= ST_HALT;
                    end else if (run_press) begin
                        state <= ST_IDLE;
                    end else if (tick == TICK_MAX) begin
                        tick   <= '0;
                        cpu_en <= 1'b1;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_en    = cpu_en;
    assign bus.running   = (state == ST_RUN);
    assign bus.halted    = (state == ST_HALT);
    assign bus.disp_mode = disp_mode;
    assign bus.step_cnt  = step_cnt;

endmodule

// File: tb/tb_up3_step_ctrl.sv
// Scoreboard bench for up3_step_ctrl: expected cpu_en cycles are queued when keys
// are driven and matched as pulses appear. Honours UP3_STEP_AUTOREPEAT_EN.
module tb_up3_step_ctrl;

    localparam int DEB    = 4;
    localparam int DIV    = 8;
    localparam int RDLY   = 16;
    localparam int LAT    = DEB + 4;  // key-down negedge to FSM reaction edge
    localparam int K_STEP = 1;
    localparam int K_RUN  = 2;
    localparam int K_MODE = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt = 0;
    int   exp_q[$];

    up3_step_ctrl_if bus();

    up3_step_ctrl #(.DEB_CYCLES(DEB), .RUN_DIV(DIV), .REPEAT_DLY(RDLY)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every cpu_en pulse must match the next queued expected cycle.
    always @(negedge clk) begin
        if (!reset && bus.cpu_en) begin
            if (exp_q.size() == 0) check("spurious_cpu_en", cyc, -1);
            else                   check("cpu_en_cycle", cyc, exp_q.pop_front());
        end
    end

    task automatic push_pulse(input int t);
        exp_q.push_back(t);
        exp_cnt++;
    endtask

    task automatic key_down(input int m, output int c);
        @(negedge clk);
        c = cyc;
        if (m & K_STEP) bus.step_key_n = 1'b0;
        if (m & K_RUN)  bus.run_key_n  = 1'b0;
        if (m & K_MODE) bus.mode_key_n = 1'b0;
    endtask

    task automatic key_up(input int hold);
        repeat (hold) @(negedge clk);
        bus.step_key_n = 1'b1;
        bus.run_key_n  = 1'b1;
        bus.mode_key_n = 1'b1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, e, l;
        bus.step_key_n = 1'b1;
        bus.run_key_n  = 1'b1;
        bus.mode_key_n = 1'b1;
        bus.halt_in    = 1'b0;

        // Reset state and quiet idle period
        do_reset();
        check("rst_cpu_en", bus.cpu_en, 0);
        check("rst_running", bus.running, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_disp_mode", bus.disp_mode, 0);
        check("rst_step_cnt", bus.step_cnt, 0);
        repeat (20) @(negedge clk);

        // Short glitch rejected, then one clean step press
        key_down(K_STEP, c);
        key_up(2);
        repeat (3) @(negedge clk);
        key_down(K_STEP, c);
        push_pulse(c + LAT);
        key_up(10);
        wait_until(c + 30);
        check("step_pending", exp_q.size(), 0);
        check("step_cnt_1", bus.step_cnt, exp_cnt);

        // Run mode: pulses every DIV cycles, stop on second run press
        key_down(K_RUN, c);
        e = c + LAT;
        for (int k = 1; k <= 4; k++) push_pulse(e + k * DIV);
        key_up(10);
        wait_until(e + 34);
        check("run_running", bus.running, 1);
        check("run_step_cnt", bus.step_cnt, exp_cnt);
        key_down(K_RUN, c2);
        l = c2 + LAT;
        for (int t = e + 5 * DIV; t < l; t += DIV) push_pulse(t);
        key_up(10);
        wait_until(l + 30);
        check("stop_running", bus.running, 0);
        check("stop_pending", exp_q.size(), 0);
        check("stop_step_cnt", bus.step_cnt, exp_cnt);

        // Halt arriving on a due tick suppresses it and is sticky
        key_down(K_RUN, c);
        e = c + LAT;
        key_up(10);
        wait_until(e + DIV - 1);
        check("pre_halt_running", bus.running, 1);
        bus.halt_in = 1'b1;
        wait_until(e + DIV);
        check("halt_halted", bus.halted, 1);
        check("halt_running", bus.running, 0);
        bus.halt_in = 1'b0;
        key_down(K_STEP | K_RUN | K_MODE, c);
        key_up(10);
        wait_until(c + 30);
        check("halt_step_cnt", bus.step_cnt, exp_cnt);
        check("halt_sticky", bus.halted, 1);
        check("halt_disp_mode", bus.disp_mode, 1);
        do_reset();
        check("post_rst_halted", bus.halted, 0);
        check("post_rst_step_cnt", bus.step_cnt, 0);
        check("post_rst_disp_mode", bus.disp_mode, 0);

        // Simultaneous step and run in idle: run wins
        key_down(K_STEP | K_RUN, c);
        e = c + LAT;
        push_pulse(e + DIV);
        key_up(10);
        wait_until(e + DIV + 2);
        check("both_running", bus.running, 1);
        check("both_pending", exp_q.size(), 0);
        check("both_step_cnt", bus.step_cnt, exp_cnt);
        do_reset();

        // Display mode toggles exactly at the press-reaction edge
        for (int i = 0; i < 2; i++) begin
            key_down(K_MODE, c);
            wait_until(c + LAT - 1);
            check("mode_before", bus.disp_mode, i);
            wait_until(c + LAT);
            check("mode_after", bus.disp_mode, 1 - i);
            key_up(10);
            repeat (15) @(negedge clk);
        end

        // Long step hold: one pulse, plus repeats when auto-repeat is built
        key_down(K_STEP, c);
        push_pulse(c + LAT);
`ifdef UP3_STEP_AUTOREPEAT_EN
        for (int t = c + LAT + RDLY; t < c + 40 + 3 + DEB; t += DIV) push_pulse(t);
`endif
        key_up(40);
        wait_until(c + 40 + 30);
        check("hold_pending", exp_q.size(), 0);
        check("hold_step_cnt", bus.step_cnt, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/up3_step_ctrl.md
Name: up3_step_ctrl

Overview:
- Front-panel execution controller for the uP3 board top level; sits directly upstream of the uP3 control unit.
- Turns raw, bouncy push-button inputs into clean single-cycle CPU clock-enable pulses, in single-step or free-run mode.
- Also latches the HEX/LEDR display-mode toggle and counts the executed steps.

Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles needed to accept a key change (10 ms at 50 MHz).
- RUN_DIV, 12500000: cycles between `cpu_en` pulses in run mode (4 Hz at 50 MHz).
- REPEAT_DLY, 25000000: hold time before step auto-repeat starts (optional feature only).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- step_key_n  in  1  raw step button, active-low, asynchronous to clk
- run_key_n  in  1  raw run/stop button, active-low, asynchronous
- mode_key_n  in  1  raw display-mode button, active-low, asynchronous
- halt_in  in  1  CPU halt request, level, synchronous to clk
- cpu_en  out  1  one-cycle enable pulse; advances the control unit one state
- running  out  1  1 while in S_RUN
- halted  out  1  1 while in S_HALT
- disp_mode  out  1  display-mode select (0 = AC/IRL/IRU, 1 = MDR/MAR/PC)
- step_cnt  out  16  count of `cpu_en` pulses issued

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values:
  - `cpu_en`, `running`, `halted`, `disp_mode` = 0; `step_cnt` = 0; FSM = S_IDLE.
  - Debounced key states = released (1); all counters = 0.
- Per key:
  - Two-flop synchroniser, then debounce counter.
  - The counter clears whenever the synced value equals the stable state; otherwise it increments.
  - At DEB_CYCLES-1 the stable state takes the synced value and the counter clears.
  - A press pulse (1 cycle) fires when the stable state goes 1->0. Release produces no pulse.
- Latency: key held low from clock edge N gives a press pulse registered at edge N+2+DEB_CYCLES, and `cpu_en` high in the following cycle.
- FSM states: S_IDLE, S_RUN, S_HALT.
- S_IDLE:
  - step press -> `cpu_en` = 1 for exactly one cycle.
  - run press -> S_RUN and the tick counter clears.
  - step and run press in the same cycle -> run wins; no step pulse.
- S_RUN:
  - Tick counter counts 0..RUN_DIV-1 and wraps.
  - `cpu_en` = 1 for the cycle after the counter reaches RUN_DIV-1, so the first pulse comes RUN_DIV cycles after entry.
  - run press -> S_IDLE with no pulse; a tick in that same cycle is dropped.
  - step press is ignored.
- halt_in = 1 in S_IDLE or S_RUN -> S_HALT next cycle. halt beats any coincident tick or step (no pulse).
- S_HALT:
  - `cpu_en` held 0; step and run presses ignored.
  - The only exit is reset.
- `step_cnt` increments on every `cpu_en` cycle and wraps from 16'hFFFF to 0.
- mode press toggles `disp_mode` in every FSM state, including S_HALT.
- `cpu_en` is never high on two consecutive cycles (requires RUN_DIV >= 2).
- Reset mid-debounce or mid-run discards all pending events; no pulse is emitted on the cycle after reset.

Optional Feature:
- Macro: UP3_STEP_AUTOREPEAT_EN.
- Defined:
  - In S_IDLE, a step key whose debounced state stays pressed for REPEAT_DLY cycles after its press pulse starts auto-repeat.
  - Auto-repeat emits `cpu_en` every RUN_DIV cycles until the key is released, run is pressed, or halt occurs.
  - A release stops it with no further pulse.
- Undefined: a held key yields exactly one pulse per press; REPEAT_DLY is unused.

Decomposition:
- Shared package up3_pkg holds:
  - typedef enum logic [1:0] step_state_t {S_IDLE=2'd0, S_RUN=2'd1, S_HALT=2'd2};
  - default DEB_CYCLES and RUN_DIV constants;
  - localparam STEP_CNT_W = 16.
- Sub-module key_debounce covers synchroniser, debounce counter and press pulse.
  - Parameter: DEB_CYCLES. Ports: clk, reset, key_n, pressed, press_pulse.
  - Instantiated three times.

Test Plan (DEB_CYCLES=4, RUN_DIV=8, REPEAT_DLY=16):
- Reset asserted 3 cycles -> all outputs 0, FSM S_IDLE; no `cpu_en` for 20 idle cycles.
- step_key_n low for 2 cycles, high, then low for 10 cycles -> exactly one `cpu_en` pulse, 7 cycles after the second falling edge; `step_cnt` = 1.
- run press, then wait 40 cycles -> `running` = 1, pulses spaced 8 cycles apart, `step_cnt` = 5; second run press -> `running` = 0, no further pulses.
- In S_RUN, raise halt_in on the cycle a tick is due -> no pulse, `halted` = 1; later step/run presses leave `step_cnt` unchanged until reset.
- step and run pressed simultaneously in S_IDLE -> `running` = 1, no pulse before the first run tick.
- mode pressed twice -> `disp_mode` goes 0->1->0. With UP3_STEP_AUTOREPEAT_EN, step held 40 cycles -> 1 + repeat pulses every 8 cycles after the 16-cycle delay; they stop on release.
